// File: rtl/seg_scan_driver.sv
// Multi-digit seven-segment driver: latched hex value, parallel and scanned views.
// Optional blink feature enabled by defining SEG_BLINK_EN.
module seg_scan_driver #(
  parameter int DIGITS    = 8,
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic                  lz_en,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [7*DIGITS-1:0]   seg_all,
  output logic [6:0]            seg_out,
  output logic [DIGITS-1:0]     an,
  output logic                  valid
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);

  typedef enum logic {EMPTY, SHOW} state_t;

  state_t                  state, state_nx;
  logic [4*DIGITS-1:0]     data_q;
  logic [DIGITS-1:0]       blank_q;
  logic                    lz_q;
  logic [PW-1:0]           pre;
  logic [IW-1:0]           idx;
  logic [DIGITS-1:0]       blink_blank;
  logic [DIGITS-1:0]       upper_zero;
  logic [DIGITS-1:0]       dig_blank;
  logic [DIGITS-1:0][6:0]  pat;
  logic [6:0]              sel_pat;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    unique case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (load) state_nx = SHOW;
  end

  assign valid = (state == SHOW);

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      blank_q <= '0;
      lz_q    <= 1'b0;
    end else if (load) begin
      data_q  <= data;
      blank_q <= blank_mask;
      lz_q    <= lz_en;
    end
  end

  // Scan prescaler and digit index free-run in both states.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == PRE_MAX) begin
      pre <= '0;
      idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
    end else begin
      pre <= pre + PW'(1);
    end
  end

`ifdef SEG_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_MAX) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  assign blink_blank = blink_phase ? blink_mask : '0;
`else
  logic unused_blink;
  assign unused_blink = ^blink_mask;
  assign blink_blank  = '0;
`endif

  // A digit is a leading zero when it and every higher nibble are zero.
  always_comb begin
    upper_zero = '0;
    dig_blank  = '0;
    pat        = '1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      upper_zero[i] = ((data_q >> (4 * i)) == '0);
      dig_blank[i]  = blank_q[i] | (lz_q & (i != 0) & upper_zero[i]) | blink_blank[i];
      if (state == SHOW && !dig_blank[i])
        pat[i] = hex7(data_q[4*i +: 4]);
    end
  end

  always_comb begin
    sel_pat = '1;
    for (int unsigned i = 0; i < DIGITS; i++)
      if (idx == IW'(i)) sel_pat = pat[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_all <= '1;
      seg_out <= '1;
      an      <= '1;
    end else begin
      seg_all <= pat;
      seg_out <= sel_pat;
      an      <= (state == SHOW) ? ~(DIGITS'(1) << idx) : '1;
    end
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised multi-digit seven-segment display driver; the successor to the single-digit hex decoder. Latches a packed hex value on a load strobe and decodes all 16 hex codes, including F. Provides two views of every digit: registered parallel segment buses for boards that drive all digits at once, and a time-multiplexed scanned output with active-low digit enables. Adds per-digit blanking, leading-zero suppression and an optional blink feature. Sits between keyboard/ALU result logic and the board display pins.

## Interface
Parameters:
- DIGITS, 8, number of digits; range 1..16
- SCAN_DIV, 1000, clock cycles each digit is held in scan mode; must be ≥ 1
- BLINK_DIV, 25000000, clock cycles per blink half-period; used only with SEG_BLINK_EN

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- load  in  1  one-cycle strobe; captures data, blank_mask, lz_en
- data  in  4*DIGITS  packed hex nibbles; digit i is data[4i+3:4i], digit 0 is least significant
- blank_mask  in  DIGITS  bit i=1 forces digit i blank
- lz_en  in  1  leading-zero suppression enable
- blink_mask  in  DIGITS  bit i=1 blinks digit i; ignored without SEG_BLINK_EN
- seg_all  out  7*DIGITS  parallel segments, digit i at [7i+6:7i], active-low, bit0=a..bit6=g
- seg_out  out  7  scanned segments for the selected digit, active-low
- an  out  DIGITS  scanned digit enables, active-low, one-cold
- valid  out  1  high once a load has been captured since reset

## Operation
- Encoding, g..a: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110; blank=1111111.
- States: EMPTY after reset, with all segments blank and an all-ones; SHOW after the first load. No other transitions; only rst returns the block to EMPTY.
- On load, the shadow registers take data, blank_mask and lz_en. Loads while in SHOW overwrite the shadows.
- Digit i is blank if any of the following holds:
  - blank_mask[i] is set;
  - lz_en is set, i>0, and every shadow nibble from i up to DIGITS-1 is zero;
  - the blink condition holds (SEG_BLINK_EN only).
- Digit 0 is never blanked by zero suppression. An all-zero value with lz_en set shows a single "0".
- Scan: the prescaler counts 0..SCAN_DIV-1. On wrap, the index advances, and goes from DIGITS-1 back to 0. an[index]=0 and seg_out shows that digit's pattern.
- Scanning runs in both states. In EMPTY, an stays all-ones.

## Timing
- Reset values: shadows 0, valid 0, seg_all all ones, seg_out 7'b1111111, an all ones, prescaler 0, index 0, blink phase 0.
- Load at edge t gives shadow and valid updated at t+1, and seg_all updated at t+2 (registered decode).
- seg_out and an are registered. They update on the cycle after the index changes.
- An index change and a load in the same cycle are independent. The scanned digit shows the new value no later than 2 cycles after the load.
- SCAN_DIV=1 makes the index advance every cycle.
- DIGITS=1 makes the index stay at 0, and an is a single bit, 0 in SHOW.
- Reset asserted mid-scan or mid-blink returns the block to the reset values on the next edge, overriding a simultaneous load.

## Configuration
- SEG_BLINK_EN defined:
  - a BLINK_DIV counter toggles the blink phase on each wrap;
  - while the phase is 1, digits with blink_mask[i] set are blank in both seg_all and seg_out;
  - blink_mask is sampled live and is not latched.
- SEG_BLINK_EN undefined: no blink counter is synthesised, blink_mask is unused, and the phase is held at 0.

## Test plan
- Reset, then 20 idle cycles → seg_all all ones, an all ones, valid=0.
- DIGITS=8: load data=32'h0123_ABCF, lz_en=0, mask=0 → from t+2, seg_all digit0=0001110, digit1=1000110, digit7=1000000; valid=1.
- Load data=32'h0000_0040 with lz_en=1 → digits 7..2 blank, digit1=0011001, digit0=1000000. Then load 0 with lz_en=1 → only digit0 shows 1000000.
- SCAN_DIV=4 after a load → an steps FE,FD,FB,…,7F,FE every 4 cycles, and seg_out matches seg_all for the selected digit.
- Load with blank_mask=8'h81 → digits 7 and 0 blank. Assert rst together with load → all outputs return to their reset values.
- With SEG_BLINK_EN and BLINK_DIV=8, blink_mask=8'h01 → digit0 alternates between its pattern and blank every 8 cycles; other digits are steady.
